l2_arbiter: RTL and testbench
=============================

# l2_arbiter

Two-client arbiter between the split L1 caches and the unified L2. It accepts line-sized miss/writeback requests from the I-cache (read-only) and the D-cache (read/write), grants one at a time, drives the single L2 request port, and routes the L2 response back to the granted client. It sits directly upstream of `l2_cache` and presents it a clean, held request that is released one cycle after `l2_resp`.

## Interface
Parameters:
- `ADDR_W`, 16, byte address width (`lc3b_word`)
- `LINE_W`, 128, cache-line width (`lc3b_c_line`)

Ports:
- `clk` in 1: single clock, all state on rising edge
- `reset` in 1: asynchronous, active-high
- `icache_read` in 1: I-cache line read request, held until `icache_resp`
- `icache_address` in ADDR_W: I-cache line address
- `icache_rdata` out LINE_W: returned line, valid with `icache_resp`
- `icache_resp` out 1: one-cycle completion pulse
- `dcache_read`, `dcache_write` in 1 each: D-cache request, held until `dcache_resp`
- `dcache_address` in ADDR_W: D-cache line address
- `dcache_wdata` in LINE_W: writeback line
- `dcache_rdata` out LINE_W: returned line, valid with `dcache_resp`
- `dcache_resp` out 1: one-cycle completion pulse
- `l2_read`, `l2_write` out 1 each: request to L2
- `l2_address` out ADDR_W; `l2_wdata` out LINE_W
- `l2_rdata` in LINE_W; `l2_resp` in 1

## Operation
- Valid request: I-side `icache_read`; D-side `dcache_read ^ dcache_write`. Both D strobes high is not a request (ignored, same rule as L2).
- States: `IDLE`, `SERVE_I`, `SERVE_D`, `DONE_I`, `DONE_D`.
- `IDLE`: if exactly one valid request, go to its `SERVE_x`; if both, select per Configuration. Latch address, wdata, and read/write kind into request registers on the transition edge.
- `SERVE_x`: drive `l2_read`/`l2_write`/`l2_address`/`l2_wdata` from the latched registers only (never combinationally from client inputs). Hold until `l2_resp`=1; then capture `l2_rdata` into the line register, go to `DONE_x`.
- `DONE_x`: `x_resp`=1 for exactly this cycle, `x_rdata` = line register; L2 strobes low; next state `IDLE`. Update `last_grant` <= x.
- `icache_rdata`/`dcache_rdata` both always driven from the one line register; only the resp pulse discriminates.
- Client dropping its request mid-`SERVE_x` is a protocol violation; the arbiter completes the latched transaction anyway.

## Timing
- Reset (async, any state): state `IDLE`; `last_grant` = I; all request/line registers 0; every output 0.
- Minimum latency request-to-resp: request seen in `IDLE` at edge N → L2 strobe from cycle N+1 → `l2_resp` at earliest cycle N+1 → `x_resp` in cycle N+2.
- L2 strobes deassert the cycle after `l2_resp`, so the L2 never re-sees a completed request.
- At least one `IDLE` cycle between consecutive grants; losing client waits, its request held, and is granted from that `IDLE` if still asserted.
- A new request arriving in `SERVE_x`/`DONE_x` is not sampled until `IDLE`.
- Reset asserted mid-`SERVE_x`: transaction abandoned, no `resp` issued, L2 strobes drop asynchronously.

## Configuration
- `L2_ARB_ROUND_ROBIN_EN` defined: on simultaneous I and D requests in `IDLE`, grant the client not in `last_grant` (after reset, D wins first).
- Undefined: fixed priority, D always wins contention; `last_grant` not implemented.

## Structure
- Add to `lc3b_types`: `lc3b_arb_state` enum (five states), `lc3b_arb_client` enum (`ARB_I`, `ARB_D`).
- One sub-module `l2_arbiter_grant`: combinational winner select from valid requests and `last_grant`, with macro-dependent body. FSM, request/line registers in `l2_arbiter`.

## Test plan
- I read 0x1230 only, L2 returns line 0xA5…A5 after 3 cycles → `l2_read`=1, `l2_address`=0x1230 for 3 cycles; `icache_resp` one cycle with 0xA5…A5; `dcache_resp` stays 0.
- D write 0x4000 wdata 0x0F…0F, `l2_resp` same cycle as grant → `l2_write`=1 one cycle, `dcache_resp` one cycle later, total 2 cycles.
- I and D read asserted together from reset, RR enabled → D served first, then I; repeat contention → I, D alternate. RR disabled → D served first every contention.
- `dcache_read`=`dcache_write`=1 with I idle → no L2 strobe, no resp for 10 cycles.
- Reset pulsed during `SERVE_I` while `l2_read`=1 → all outputs 0 immediately, no `icache_resp`; fresh I request afterward completes normally.
- D changes `dcache_address` from 0x4000 to 0x5000 during `SERVE_D` → `l2_address` remains 0x4000 until completion.

Source files
------------

// File: rtl/l2_arbiter_pkg.sv
// Shared types for the L1-to-L2 arbiter: FSM states and client identifiers.
package l2_arbiter_pkg;

    localparam int ARB_ADDR_W = 16;
    localparam int ARB_LINE_W = 128;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        SERVE_I = 3'd1,
        SERVE_D = 3'd2,
        DONE_I  = 3'd3,
        DONE_D  = 3'd4
    } lc3b_arb_state;

    typedef enum logic {
        ARB_I = 1'b0,
        ARB_D = 1'b1
    } lc3b_arb_client;

    // Both D strobes high is not a request, same rule the L2 applies.
    function automatic logic d_req_valid(input logic rd, input logic wr);
        return rd ^ wr;
    endfunction

endpackage

// File: rtl/l2_arbiter_if.sv
// Bundle of the I-cache, D-cache and L2 sides of the arbiter.
// slave: arbiter view; master: the surrounding caches / L2 view.
interface l2_arbiter_if #(
    parameter int ADDR_W = 16,
    parameter int LINE_W = 128
) ();
    logic              icache_read;
    logic [ADDR_W-1:0] icache_address;
    logic [LINE_W-1:0] icache_rdata;
    logic              icache_resp;

    logic              dcache_read;
    logic              dcache_write;
    logic [ADDR_W-1:0] dcache_address;
    logic [LINE_W-1:0] dcache_wdata;
    logic [LINE_W-1:0] dcache_rdata;
    logic              dcache_resp;

    logic              l2_read;
    logic              l2_write;
    logic [ADDR_W-1:0] l2_address;
    logic [LINE_W-1:0] l2_wdata;
    logic [LINE_W-1:0] l2_rdata;
    logic              l2_resp;

    modport slave (
        input  icache_read, icache_address,
        input  dcache_read, dcache_write, dcache_address, dcache_wdata,
        input  l2_rdata, l2_resp,
        output icache_rdata, icache_resp,
        output dcache_rdata, dcache_resp,
        output l2_read, l2_write, l2_address, l2_wdata
    );

    modport master (
        output icache_read, icache_address,
        output dcache_read, dcache_write, dcache_address, dcache_wdata,
        output l2_rdata, l2_resp,
        input  icache_rdata, icache_resp,
        input  dcache_rdata, dcache_resp,
        input  l2_read, l2_write, l2_address, l2_wdata
    );
endinterface

// File: rtl/l2_arbiter_grant.sv
// Combinational winner select between the I and D clients.
// L2_ARB_ROUND_ROBIN_EN: alternate on contention; otherwise D always wins.
module l2_arbiter_grant
    import l2_arbiter_pkg::*;
(
    input  logic           i_i_valid,
    input  logic           i_d_valid,
`ifdef L2_ARB_ROUND_ROBIN_EN
    input  lc3b_arb_client i_last_grant,
`endif
    output logic           o_any,
    output lc3b_arb_client o_winner
);

    always_comb begin
        o_any    = i_i_valid | i_d_valid;
        o_winner = ARB_I;
        if (i_i_valid && i_d_valid) begin
`ifdef L2_ARB_ROUND_ROBIN_EN
            o_winner = (i_last_grant == ARB_I) ? ARB_D : ARB_I;
`else
            o_winner = ARB_D;
`endif
        end else if (i_d_valid) begin
            o_winner = ARB_D;
        end
    end

endmodule

// File: rtl/l2_arbiter.sv
// Two-client arbiter between split L1 caches and the unified L2.
// Optional L2_ARB_ROUND_ROBIN_EN selects round-robin contention resolution.
module l2_arbiter
    import l2_arbiter_pkg::*;
#(
    parameter int ADDR_W = ARB_ADDR_W,
    parameter int LINE_W = ARB_LINE_W
) (
    input  logic        clk,
    input  logic        reset,
    l2_arbiter_if.slave io_bus
);

    lc3b_arb_state     r_state;
    lc3b_arb_state     w_state_next;
    logic [ADDR_W-1:0] r_addr;
    logic [LINE_W-1:0] r_wdata;
    logic [LINE_W-1:0] r_line;
    logic              r_write;

    logic              w_i_valid;
    logic              w_d_valid;
    logic              w_any;
    lc3b_arb_client    w_winner;
    logic              w_latch;
    logic              w_capture;

    assign w_i_valid = io_bus.icache_read;
    assign w_d_valid = d_req_valid(io_bus.dcache_read, io_bus.dcache_write);

`ifdef L2_ARB_ROUND_ROBIN_EN
    lc3b_arb_client r_last_grant;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_last_grant <= ARB_I;
        end else if (r_state == DONE_I) begin
            r_last_grant <= ARB_I;
        end else if (r_state == DONE_D) begin
            r_last_grant <= ARB_D;
        end
    end

    l2_arbiter_grant u_grant (
        .i_i_valid    (w_i_valid),
        .i_d_valid    (w_d_valid),
        .i_last_grant (r_last_grant),
        .o_any        (w_any),
        .o_winner     (w_winner)
    );
`else
    l2_arbiter_grant u_grant (
        .i_i_valid (w_i_valid),
        .i_d_valid (w_d_valid),
        .o_any     (w_any),
        .o_winner  (w_winner)
    );
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // All L2-facing outputs come from state and latched registers, so a
    // client changing its inputs mid-transaction cannot disturb the L2.
    always_comb begin
        w_state_next        = r_state;
        w_latch             = 1'b0;
        w_capture           = 1'b0;
        io_bus.l2_read      = 1'b0;
        io_bus.l2_write     = 1'b0;
        io_bus.icache_resp  = 1'b0;
        io_bus.dcache_resp  = 1'b0;
        io_bus.l2_address   = r_addr;
        io_bus.l2_wdata     = r_wdata;
        io_bus.icache_rdata = r_line;
        io_bus.dcache_rdata = r_line;

        case (r_state)
            IDLE: begin
                if (w_any) begin
                    w_latch      = 1'b1;
                    w_state_next = (w_winner == ARB_D) ? SERVE_D : SERVE_I;
                end
            end
            SERVE_I: begin
                io_bus.l2_read = 1'b1;
                if (io_bus.l2_resp) begin
                    w_capture    = 1'b1;
                    w_state_next = DONE_I;
                end
            end
            SERVE_D: begin
                io_bus.l2_read  = ~r_write;
                io_bus.l2_write = r_write;
                if (io_bus.l2_resp) begin
                    w_capture    = 1'b1;
                    w_state_next = DONE_D;
                end
            end
            DONE_I: begin
                io_bus.icache_resp = 1'b1;
                w_state_next       = IDLE;
            end
            DONE_D: begin
                io_bus.dcache_resp = 1'b1;
                w_state_next       = IDLE;
            end
            default: begin
                w_state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_addr  <= '0;
            r_wdata <= '0;
            r_write <= 1'b0;
            r_line  <= '0;
        end else begin
            if (w_latch) begin
                if (w_winner == ARB_D) begin
                    r_addr  <= io_bus.dcache_address;
                    r_wdata <= io_bus.dcache_wdata;
                    r_write <= io_bus.dcache_write;
                end else begin
                    r_addr  <= io_bus.icache_address;
                    r_wdata <= '0;
                    r_write <= 1'b0;
                end
            end
            if (w_capture) begin
                r_line <= io_bus.l2_rdata;
            end
        end
    end

endmodule

// File: tb/tb_l2_arbiter.sv
// Randomized bench for l2_arbiter against a transaction-level reference model.
// Build with L2_ARB_ROUND_ROBIN_EN to check the round-robin contention rule.
module tb_l2_arbiter;

    logic clk = 1'b0;
    logic reset;

    always #5 clk = ~clk;

    l2_arbiter_if #(.ADDR_W(16), .LINE_W(128)) bus ();

    l2_arbiter #(.ADDR_W(16), .LINE_W(128)) dut (
        .clk    (clk),
        .reset  (reset),
        .io_bus (bus)
    );

    int n_checks = 0;
    int n_pass   = 0;
    int n_txn    = 0;

    // Reference model: transaction in flight (none / on L2 / completing)
    int           m_phase;
    int           m_cur;     // 0 = I client, 1 = D client
    int           m_last;
    logic [15:0]  m_addr;
    logic         m_wr;
    logic [127:0] m_wdata;
    logic [127:0] m_line;

    // Inputs as they were just before the most recent clock edge
    logic         p_ir, p_dr, p_dw, p_l2resp;
    logic [15:0]  p_ia, p_da;
    logic [127:0] p_dwd, p_rd;

    bit auto_drive;
    bit l2_hold;
    int d_bad;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h, want %0h", tag, got, exp);
    endtask

    function automatic logic [127:0] rand128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    task automatic model_reset();
        m_phase = 0;
        m_cur   = 0;
        m_last  = 0;
        m_addr  = '0;
        m_wr    = 1'b0;
        m_wdata = '0;
        m_line  = '0;
    endtask

    task automatic step_model();
        bit iv, dv;
        int win;
        if (m_phase == 0) begin
            iv = p_ir;
            dv = p_dr ^ p_dw;
            if (iv || dv) begin
                if (iv && dv) begin
`ifdef L2_ARB_ROUND_ROBIN_EN
                    win = (m_last == 0) ? 1 : 0;
`else
                    win = 1;
`endif
                end else begin
                    win = dv ? 1 : 0;
                end
                m_cur   = win;
                m_addr  = (win == 1) ? p_da : p_ia;
                m_wr    = (win == 1) && p_dw;
                m_wdata = p_dwd;
                m_phase = 1;
            end
        end else if (m_phase == 1) begin
            if (p_l2resp) begin
                m_line  = p_rd;
                m_phase = 2;
            end
        end else begin
            m_last  = m_cur;
            m_phase = 0;
        end
    endtask

    task automatic check_outputs();
        check("l2_read", bus.l2_read, (m_phase == 1) && !m_wr);
        check("l2_write", bus.l2_write, (m_phase == 1) && m_wr);
        if (m_phase == 1) begin
            check("l2_address", bus.l2_address, m_addr);
            if (m_wr) check("l2_wdata", bus.l2_wdata, m_wdata);
        end
        check("icache_resp", bus.icache_resp, (m_phase == 2) && (m_cur == 0));
        check("dcache_resp", bus.dcache_resp, (m_phase == 2) && (m_cur == 1));
        if (m_phase == 2) begin
            n_txn++;
            if (m_cur == 0) check("icache_rdata", bus.icache_rdata, m_line);
            else            check("dcache_rdata", bus.dcache_rdata, m_line);
            $display("txn %0d: %s %s addr=%h line=%h", n_txn,
                     (m_cur == 0) ? "I" : "D", m_wr ? "write" : "read", m_addr, m_line);
        end
    endtask

    task automatic drive_next();
        int k;
        if ((bus.l2_read || bus.l2_write) && !l2_hold)
            bus.l2_resp = ($urandom_range(0, 2) == 0);
        else
            bus.l2_resp = 1'b0;
        bus.l2_rdata = rand128();

        if (bus.icache_resp) begin
            bus.icache_read = 1'b0;
        end else if (auto_drive && !bus.icache_read && $urandom_range(0, 3) == 0) begin
            bus.icache_read    = 1'b1;
            bus.icache_address = 16'($urandom) & 16'hFFF0;
        end

        if (bus.dcache_resp) begin
            bus.dcache_read  = 1'b0;
            bus.dcache_write = 1'b0;
        end else if (bus.dcache_read && bus.dcache_write) begin
            if (d_bad == 0) begin
                bus.dcache_read  = 1'b0;
                bus.dcache_write = 1'b0;
            end else begin
                d_bad--;
            end
        end else if (!(bus.dcache_read || bus.dcache_write)) begin
            if (auto_drive && $urandom_range(0, 3) == 0) begin
                k = $urandom_range(0, 7);
                if (k == 0) begin
                    bus.dcache_read  = 1'b1;
                    bus.dcache_write = 1'b1;
                    d_bad = $urandom_range(0, 3);
                end else begin
                    bus.dcache_read    = (k < 4);
                    bus.dcache_write   = (k >= 4);
                    bus.dcache_address = 16'($urandom) & 16'hFFF0;
                    bus.dcache_wdata   = rand128();
                end
            end
        end else if (auto_drive && $urandom_range(0, 15) == 0) begin
            // Client misbehaves by moving its address while held
            bus.dcache_address = 16'($urandom) & 16'hFFF0;
        end
    endtask

    task automatic cycle();
        p_ir     = bus.icache_read;
        p_ia     = bus.icache_address;
        p_dr     = bus.dcache_read;
        p_dw     = bus.dcache_write;
        p_da     = bus.dcache_address;
        p_dwd    = bus.dcache_wdata;
        p_l2resp = bus.l2_resp;
        p_rd     = bus.l2_rdata;
        @(posedge clk);
        #1;
        step_model();
        check_outputs();
        drive_next();
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_l2_read"},  bus.l2_read, 1'b0);
        check({tag, "_l2_write"}, bus.l2_write, 1'b0);
        check({tag, "_l2_addr"},  bus.l2_address, 16'h0);
        check({tag, "_l2_wdata"}, bus.l2_wdata, 128'h0);
        check({tag, "_i_resp"},   bus.icache_resp, 1'b0);
        check({tag, "_d_resp"},   bus.dcache_resp, 1'b0);
        check({tag, "_i_rdata"},  bus.icache_rdata, 128'h0);
        check({tag, "_d_rdata"},  bus.dcache_rdata, 128'h0);
    endtask

    initial begin
        bit got_resp;
        bit seen;

        reset              = 1'b1;
        bus.icache_read    = 1'b0;
        bus.icache_address = '0;
        bus.dcache_read    = 1'b0;
        bus.dcache_write   = 1'b0;
        bus.dcache_address = '0;
        bus.dcache_wdata   = '0;
        bus.l2_rdata       = '0;
        bus.l2_resp        = 1'b0;
        auto_drive         = 1'b0;
        l2_hold            = 1'b0;
        d_bad              = 0;
        model_reset();

        repeat (3) @(posedge clk);
        #1;
        check_all_zero("reset");
        reset = 1'b0;

        // Both D strobes high with I idle: never a request
        bus.dcache_read  = 1'b1;
        bus.dcache_write = 1'b1;
        d_bad            = 9;
        repeat (12) cycle();

        // Contention straight out of reset, then random traffic
        bus.icache_read    = 1'b1;
        bus.icache_address = 16'h1230;
        bus.dcache_read    = 1'b1;
        bus.dcache_address = 16'h4000;
        auto_drive         = 1'b1;
        repeat (3000) cycle();

        // Drain, then abort an I transaction with reset
        auto_drive = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 300 && !seen; i++) begin
            cycle();
            seen = (m_phase == 0) && !bus.icache_read && !bus.dcache_read && !bus.dcache_write;
        end
        check("drain_done", seen, 1'b1);

        bus.icache_read    = 1'b1;
        bus.icache_address = 16'h1230;
        l2_hold            = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 10 && !seen; i++) begin
            cycle();
            seen = bus.l2_read;
        end
        check("abort_l2_read_seen", seen, 1'b1);
        #2;
        reset = 1'b1;
        #1;
        check_all_zero("abort");
        @(posedge clk);
        #1;
        check("abort_no_i_resp", bus.icache_resp, 1'b0);
        check("abort_l2_read_low", bus.l2_read, 1'b0);
        reset = 1'b0;
        model_reset();
        l2_hold = 1'b0;

        // The still-held I request must complete after reset
        got_resp = 1'b0;
        for (int i = 0; i < 60 && !got_resp; i++) begin
            got_resp = bus.icache_resp;
            if (!got_resp) cycle();
        end
        check("fresh_i_done", got_resp, 1'b1);
        repeat (4) cycle();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
